// File: rtl/ysyx_22040237_wb_ctrl.sv
// Writeback controller: round-robin ALU/LSU arbitration onto a registered register-file write port,
// retire counter and busy scoreboard. Optional bypass ports under YSYX_22040237_WB_BYPASS_EN.
module ysyx_22040237_wb_ctrl #(
    parameter int XLEN  = 64,
    parameter int CNT_W = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             a_valid,
    output logic             a_ready,
    input  logic [4:0]       a_rd,
    input  logic [XLEN-1:0]  a_data,
    input  logic             l_valid,
    output logic             l_ready,
    input  logic [4:0]       l_rd,
    input  logic [XLEN-1:0]  l_data,
    input  logic             iss_en,
    input  logic [4:0]       iss_rd,
    output logic [31:0]      busy,
    output logic             reg_wr_en,
    output logic [4:0]       wr_addr,
    output logic [XLEN-1:0]  wr_data,
`ifdef YSYX_22040237_WB_BYPASS_EN
    input  logic [4:0]       byp_rd1,
    input  logic [4:0]       byp_rd2,
    output logic             byp_hit1,
    output logic             byp_hit2,
    output logic [XLEN-1:0]  byp_data1,
    output logic [XLEN-1:0]  byp_data2,
`endif
    output logic [CNT_W-1:0] retire_cnt
);

    localparam logic SRC_ALU = 1'b0;
    localparam logic SRC_LSU = 1'b1;

    logic             last;
    logic             xfer;
    logic [4:0]       sel_rd;
    logic [XLEN-1:0]  sel_data;
    logic [31:0]      busy_nxt;

    // The source that did not win last time takes any conflict; a lone requester always wins.
    always_comb begin
        a_ready = 1'b0;
        l_ready = 1'b0;
        if (!rst) begin
            if (a_valid && l_valid) begin
                a_ready = (last == SRC_LSU);
                l_ready = (last == SRC_ALU);
            end else begin
                a_ready = a_valid;
                l_ready = l_valid;
            end
        end
    end

    always_comb begin
        xfer     = a_ready || l_ready;
        sel_rd   = l_ready ? l_rd   : a_rd;
        sel_data = l_ready ? l_data : a_data;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            last       <= SRC_ALU;
            reg_wr_en  <= 1'b0;
            wr_addr    <= '0;
            wr_data    <= '0;
            retire_cnt <= '0;
        end else if (xfer) begin
            last       <= l_ready ? SRC_LSU : SRC_ALU;
            reg_wr_en  <= (sel_rd != 5'd0);
            wr_addr    <= sel_rd;
            wr_data    <= sel_data;
            retire_cnt <= retire_cnt + {{(CNT_W-1){1'b0}}, 1'b1};
        end else begin
            reg_wr_en  <= 1'b0;
        end
    end

    // Clear is applied before set so a same-cycle reissue keeps the register pending.
    always_comb begin
        busy_nxt = busy;
        if (reg_wr_en)
            busy_nxt[wr_addr] = 1'b0;
        if (iss_en && (iss_rd != 5'd0))
            busy_nxt[iss_rd] = 1'b1;
        busy_nxt[0] = 1'b0;
    end

    always_ff @(posedge clk) begin
        if (rst)
            busy <= '0;
        else
            busy <= busy_nxt;
    end

`ifdef YSYX_22040237_WB_BYPASS_EN
    always_comb begin
        byp_hit1  = reg_wr_en && (wr_addr == byp_rd1) && (byp_rd1 != 5'd0);
        byp_hit2  = reg_wr_en && (wr_addr == byp_rd2) && (byp_rd2 != 5'd0);
        byp_data1 = wr_data;
        byp_data2 = wr_data;
    end
`endif

endmodule

// File: tb/tb_ysyx_22040237_wb_ctrl.sv
// Directed bench for ysyx_22040237_wb_ctrl: vector table for arbitration/scoreboard, hand sequences for reset.
module tb_ysyx_22040237_wb_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        a_valid, l_valid, iss_en;
    logic [4:0]  a_rd, l_rd, iss_rd;
    logic [63:0] a_data, l_data;
    logic        a_ready, l_ready, reg_wr_en;
    logic [4:0]  wr_addr;
    logic [63:0] wr_data;
    logic [31:0] busy, retire_cnt;
    logic        a_ready_w, l_ready_w, reg_wr_en_w;
    logic [4:0]  wr_addr_w;
    logic [63:0] wr_data_w;
    logic [31:0] busy_w;
    logic [1:0]  retire_cnt_w;
`ifdef YSYX_22040237_WB_BYPASS_EN
    logic [4:0]  byp_rd1, byp_rd2, byp_rd1_w, byp_rd2_w;
    logic        byp_hit1, byp_hit2, byp_hit1_w, byp_hit2_w;
    logic [63:0] byp_data1, byp_data2, byp_data1_w, byp_data2_w;
`endif

    int unsigned n_cmp = 0;
    int unsigned n_bad = 0;

    always #5 clk = ~clk;

    ysyx_22040237_wb_ctrl #(.XLEN(64), .CNT_W(32)) u_dut (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready), .a_rd(a_rd), .a_data(a_data),
        .l_valid(l_valid), .l_ready(l_ready), .l_rd(l_rd), .l_data(l_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .busy(busy),
        .reg_wr_en(reg_wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
`ifdef YSYX_22040237_WB_BYPASS_EN
        .byp_rd1(byp_rd1), .byp_rd2(byp_rd2), .byp_hit1(byp_hit1), .byp_hit2(byp_hit2),
        .byp_data1(byp_data1), .byp_data2(byp_data2),
`endif
        .retire_cnt(retire_cnt)
    );

    // Narrow-counter copy on the same stimulus, used to observe wrap-around.
    ysyx_22040237_wb_ctrl #(.XLEN(64), .CNT_W(2)) u_dut_w (
        .clk(clk), .rst(rst),
        .a_valid(a_valid), .a_ready(a_ready_w), .a_rd(a_rd), .a_data(a_data),
        .l_valid(l_valid), .l_ready(l_ready_w), .l_rd(l_rd), .l_data(l_data),
        .iss_en(iss_en), .iss_rd(iss_rd), .busy(busy_w),
        .reg_wr_en(reg_wr_en_w), .wr_addr(wr_addr_w), .wr_data(wr_data_w),
`ifdef YSYX_22040237_WB_BYPASS_EN
        .byp_rd1(byp_rd1_w), .byp_rd2(byp_rd2_w), .byp_hit1(byp_hit1_w), .byp_hit2(byp_hit2_w),
        .byp_data1(byp_data1_w), .byp_data2(byp_data2_w),
`endif
        .retire_cnt(retire_cnt_w)
    );

    typedef struct {
        logic        av;
        logic [4:0]  ard;
        logic [63:0] ad;
        logic        lv;
        logic [4:0]  lrd;
        logic [63:0] ld;
        logic        ie;
        logic [4:0]  ird;
        logic        ea;
        logic        el;
        logic        ewe;
        logic [4:0]  eaddr;
        logic [63:0] edata;
        logic [31:0] ecnt;
        logic [31:0] ebusy;
    } vec_t;

    vec_t vecs[13];

    function automatic vec_t mk(logic av, logic [4:0] ard, logic [63:0] ad,
                                logic lv, logic [4:0] lrd, logic [63:0] ld,
                                logic ie, logic [4:0] ird,
                                logic ea, logic el, logic ewe, logic [4:0] eaddr,
                                logic [63:0] edata, logic [31:0] ecnt, logic [31:0] ebusy);
        vec_t v;
        v.av = av; v.ard = ard; v.ad = ad; v.lv = lv; v.lrd = lrd; v.ld = ld;
        v.ie = ie; v.ird = ird; v.ea = ea; v.el = el; v.ewe = ewe;
        v.eaddr = eaddr; v.edata = edata; v.ecnt = ecnt; v.ebusy = ebusy;
        return v;
    endfunction

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
        end
    endtask

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        a_valid = 1'b0; a_rd = '0; a_data = '0;
        l_valid = 1'b0; l_rd = '0; l_data = '0;
        iss_en  = 1'b0; iss_rd = '0;
    endtask

    initial begin
        // Arbitration, x0 handling, scoreboard set/clear and set-wins-over-clear, in sequence from reset.
        vecs[0]  = mk(1, 5, 64'h1234, 0, 0, 0,        0, 0,  1, 0, 1, 5, 64'h1234, 1, 32'h0);
        vecs[1]  = mk(1, 3, 64'hA3,   1, 4, 64'hB4,   0, 0,  0, 1, 1, 4, 64'hB4,   2, 32'h0);
        vecs[2]  = mk(1, 3, 64'hA3,   1, 4, 64'hB4,   0, 0,  1, 0, 1, 3, 64'hA3,   3, 32'h0);
        vecs[3]  = mk(1, 3, 64'hA3,   1, 4, 64'hB4,   0, 0,  0, 1, 1, 4, 64'hB4,   4, 32'h0);
        vecs[4]  = mk(1, 3, 64'hA3,   1, 4, 64'hB4,   0, 0,  1, 0, 1, 3, 64'hA3,   5, 32'h0);
        vecs[5]  = mk(0, 0, 0,        1, 0, 64'hFFFF, 0, 0,  0, 1, 0, 0, 64'hFFFF, 6, 32'h0);
        vecs[6]  = mk(0, 0, 0,        0, 0, 0,        1, 7,  0, 0, 0, 0, 64'hFFFF, 6, 32'h80);
        vecs[7]  = mk(1, 7, 64'h77,   0, 0, 0,        0, 0,  1, 0, 1, 7, 64'h77,   7, 32'h80);
        vecs[8]  = mk(0, 0, 0,        0, 0, 0,        0, 0,  0, 0, 0, 7, 64'h77,   7, 32'h0);
        vecs[9]  = mk(0, 0, 0,        0, 0, 0,        1, 7,  0, 0, 0, 7, 64'h77,   7, 32'h80);
        vecs[10] = mk(1, 7, 64'h99,   0, 0, 0,        0, 0,  1, 0, 1, 7, 64'h99,   8, 32'h80);
        vecs[11] = mk(0, 0, 0,        1, 2, 64'h22,   1, 7,  0, 1, 1, 2, 64'h22,   9, 32'h80);
        vecs[12] = mk(0, 0, 0,        0, 0, 0,        1, 0,  0, 0, 0, 2, 64'h22,   9, 32'h80);

        idle_inputs();
`ifdef YSYX_22040237_WB_BYPASS_EN
        byp_rd1 = '0; byp_rd2 = '0; byp_rd1_w = '0; byp_rd2_w = '0;
`endif
        rst = 1'b1;
        a_valid = 1'b1; a_rd = 5'd5; a_data = 64'h5555;
        #2;
        check("rst_a_ready", {63'd0, a_ready}, 64'd0);
        tick();
        tick();
        check("rst_a_ready2", {63'd0, a_ready}, 64'd0);
        check("rst_reg_wr_en", {63'd0, reg_wr_en}, 64'd0);
        check("rst_wr_addr", {59'd0, wr_addr}, 64'd0);
        check("rst_wr_data", wr_data, 64'd0);
        check("rst_busy", {32'd0, busy}, 64'd0);
        check("rst_retire_cnt", {32'd0, retire_cnt}, 64'd0);
        rst = 1'b0;
        idle_inputs();

        for (int i = 0; i < 13; i++) begin
            a_valid = vecs[i].av; a_rd = vecs[i].ard; a_data = vecs[i].ad;
            l_valid = vecs[i].lv; l_rd = vecs[i].lrd; l_data = vecs[i].ld;
            iss_en  = vecs[i].ie; iss_rd = vecs[i].ird;
            #2;
            check($sformatf("v%0d_a_ready", i), {63'd0, a_ready}, {63'd0, vecs[i].ea});
            check($sformatf("v%0d_l_ready", i), {63'd0, l_ready}, {63'd0, vecs[i].el});
            tick();
            idle_inputs();
            check($sformatf("v%0d_reg_wr_en", i), {63'd0, reg_wr_en}, {63'd0, vecs[i].ewe});
            check($sformatf("v%0d_wr_addr", i), {59'd0, wr_addr}, {59'd0, vecs[i].eaddr});
            check($sformatf("v%0d_wr_data", i), wr_data, vecs[i].edata);
            check($sformatf("v%0d_retire_cnt", i), {32'd0, retire_cnt}, {32'd0, vecs[i].ecnt});
            check($sformatf("v%0d_cnt_wrap", i), {62'd0, retire_cnt_w}, {62'd0, vecs[i].ecnt[1:0]});
            check($sformatf("v%0d_busy", i), {32'd0, busy}, {32'd0, vecs[i].ebusy});
        end

`ifdef YSYX_22040237_WB_BYPASS_EN
        a_valid = 1'b1; a_rd = 5'd9; a_data = 64'hABCD;
        tick();
        idle_inputs();
        byp_rd1 = 5'd9;
        #1;
        check("byp_hit1", {63'd0, byp_hit1}, 64'd1);
        check("byp_data1", byp_data1, 64'hABCD);
        byp_rd1 = 5'd0;
        #1;
        check("byp_hit1_x0", {63'd0, byp_hit1}, 64'd0);
        tick();
`endif

        // Reset while a write is pending in the output stage drops it and clears all state.
        a_valid = 1'b1; a_rd = 5'd6; a_data = 64'h66;
        iss_en = 1'b1; iss_rd = 5'd10;
        tick();
        iss_en = 1'b0;
        check("mid_reg_wr_en", {63'd0, reg_wr_en}, 64'd1);
        check("mid_wr_addr", {59'd0, wr_addr}, 64'd6);
        rst = 1'b1;
        #1;
        check("mid_rst_a_ready", {63'd0, a_ready}, 64'd0);
        tick();
        check("mid_rst_reg_wr_en", {63'd0, reg_wr_en}, 64'd0);
        check("mid_rst_busy", {32'd0, busy}, 64'd0);
        check("mid_rst_retire_cnt", {32'd0, retire_cnt}, 64'd0);
        rst = 1'b0;
        #1;
        check("post_rst_a_ready", {63'd0, a_ready}, 64'd1);
        tick();
        idle_inputs();
        check("post_rst_wr_addr", {59'd0, wr_addr}, 64'd6);
        check("post_rst_retire_cnt", {32'd0, retire_cnt}, 64'd1);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
